// File: rtl/dispense_pkg.sv
// Shared types and recipe table for the paint dispense scheduler.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package dispense_pkg;

    // Channel indices used to select a column of the recipe table.
    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_Y = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    // 4-bit state encoding; also driven out on the phase port for debug LEDs.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_R_DROP = 4'd2,
        ST_R2Y    = 4'd3,
        ST_Y_DROP = 4'd4,
        ST_Y2B    = 4'd5,
        ST_B_DROP = 4'd6,
        ST_B2R    = 4'd7,
        ST_DONE   = 4'd8
    } state_e;

    function automatic logic color_ok(input logic [3:0] color);
        return color < 4'd4;
    endfunction

    // Stroke rounds per channel for each supported colour; unsupported
    // colours return zero everywhere.
    function automatic logic [3:0] rounds(input logic [3:0] color, input logic [1:0] ch);
        logic [3:0] r_n;
        logic [3:0] y_n;
        logic [3:0] b_n;
        case (color)
            4'd0:    begin r_n = 4'd5; y_n = 4'd7; b_n = 4'd9; end
            4'd1:    begin r_n = 4'd3; y_n = 4'd0; b_n = 4'd6; end
            4'd2:    begin r_n = 4'd0; y_n = 4'd8; b_n = 4'd2; end
            4'd3:    begin r_n = 4'd4; y_n = 4'd4; b_n = 4'd4; end
            default: begin r_n = 4'd0; y_n = 4'd0; b_n = 4'd0; end
        endcase
        case (ch)
            CH_R:    return r_n;
            CH_Y:    return y_n;
            default: return b_n;
        endcase
    endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Motor step tick generator: one-cycle tick every STEP_DIV cycles while run is high.
// Latency: first tick STEP_DIV cycles after run rises; counter parks at 0 when run is low.
// Backpressure: none. Ports: clk, rst (sync active-low), run in; tick out.
module step_tick_gen #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The count is deliberately not cleared between phases: phases change
    // only on a tick, where the count wraps to 0 anyway.
    always_comb begin
        cnt_d = '0;
        if (run && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/dispense_scheduler.sv
// Sequences red/yellow/blue dispense motors through one recipe per accepted colour_id.
// Latency: enables follow state by one cycle; done 2 + STEP_DIV*((R+Y+B)*2*DEPTH + 3*MOVE) cycles after accept.
// Backpressure: req_ready only in IDLE; requests while busy are ignored, not queued.
// Ports: clk, rst (sync active-low); req_valid/req_color/req_ready request handshake; abort;
//        en_r/en_y/en_b/dir motor drive; busy, done, err, aborted status; phase = state for debug.
module dispense_scheduler
    import dispense_pkg::*;
#(
    parameter int STEP_DIV = 4,
    parameter int DEPTH    = 5,
    parameter int MOVE     = 2,
    parameter int RND_W    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [3:0] req_color,
    output logic       req_ready,
    input  logic       abort,
    output logic       en_r,
    output logic       en_y,
    output logic       en_b,
    output logic       dir,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       aborted,
    output logic [3:0] phase
);

    localparam int SEC_MAX = (2 * DEPTH > MOVE) ? 2 * DEPTH : MOVE;
    localparam int SEC_W   = $clog2(SEC_MAX + 1);

    state_e            state_q, state_d;
    logic [3:0]        color_q, color_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [RND_W-1:0]  rnd_q, rnd_d;
    logic [RND_W-1:0]  rnds_r_q, rnds_r_d;
    logic [RND_W-1:0]  rnds_y_q, rnds_y_d;
    logic [RND_W-1:0]  rnds_b_q, rnds_b_d;

    logic en_r_q, en_y_q, en_b_q, dir_q, done_q, err_q, aborted_q;

    logic             tick;
    logic             run;
    logic             is_drop;
    logic             is_move;
    logic             kill;
    logic             sec_last_drop;
    logic             sec_last_move;
    logic             rnd_last;
    logic [RND_W-1:0] cur_rnds;

    assign is_drop = (state_q == ST_R_DROP) || (state_q == ST_Y_DROP) || (state_q == ST_B_DROP);
    assign is_move = (state_q == ST_R2Y) || (state_q == ST_Y2B) || (state_q == ST_B2R);
    assign run     = is_drop || is_move;

    // Abort is honoured everywhere except IDLE (nothing to cancel) and DONE
    // (the recipe has already finished dispensing).
    assign kill = abort && (state_q != ST_IDLE) && (state_q != ST_DONE);

    always_comb begin
        case (state_q)
            ST_Y_DROP: cur_rnds = rnds_y_q;
            ST_B_DROP: cur_rnds = rnds_b_q;
            default:   cur_rnds = rnds_r_q;
        endcase
    end

    assign sec_last_drop = (sec_q == SEC_W'(2 * DEPTH - 1));
    assign sec_last_move = (sec_q == SEC_W'(MOVE - 1));
    assign rnd_last      = (rnd_q == cur_rnds - RND_W'(1));

    step_tick_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        color_d  = color_q;
        sec_d    = sec_q;
        rnd_d    = rnd_q;
        rnds_r_d = rnds_r_q;
        rnds_y_d = rnds_y_q;
        rnds_b_d = rnds_b_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && color_ok(req_color)) begin
                    state_d = ST_LOAD;
                    color_d = req_color;
                end
            end
            ST_LOAD: begin
                rnds_r_d = RND_W'(rounds(color_q, CH_R));
                rnds_y_d = RND_W'(rounds(color_q, CH_Y));
                rnds_b_d = RND_W'(rounds(color_q, CH_B));
                sec_d    = '0;
                rnd_d    = '0;
                // A zero-round red channel goes straight to the first move.
                state_d  = (rounds(color_q, CH_R) != 4'd0) ? ST_R_DROP : ST_R2Y;
            end
            ST_R_DROP, ST_Y_DROP, ST_B_DROP: begin
                if (tick) begin
                    if (sec_last_drop) begin
                        sec_d = '0;
                        if (rnd_last) begin
                            rnd_d = '0;
                            case (state_q)
                                ST_R_DROP: state_d = ST_R2Y;
                                ST_Y_DROP: state_d = ST_Y2B;
                                default:   state_d = ST_B2R;
                            endcase
                        end else begin
                            rnd_d = rnd_q + RND_W'(1);
                        end
                    end else begin
                        sec_d = sec_q + SEC_W'(1);
                    end
                end
            end
            ST_R2Y, ST_Y2B, ST_B2R: begin
                if (tick) begin
                    if (sec_last_move) begin
                        sec_d = '0;
                        // Zero-round channels are skipped by chaining moves.
                        case (state_q)
                            ST_R2Y:  state_d = (rnds_y_q != '0) ? ST_Y_DROP : ST_Y2B;
                            ST_Y2B:  state_d = (rnds_b_q != '0) ? ST_B_DROP : ST_B2R;
                            default: state_d = ST_DONE;
                        endcase
                    end else begin
                        sec_d = sec_q + SEC_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (kill) begin
            state_d = ST_IDLE;
            sec_d   = '0;
            rnd_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            color_q   <= '0;
            sec_q     <= '0;
            rnd_q     <= '0;
            rnds_r_q  <= '0;
            rnds_y_q  <= '0;
            rnds_b_q  <= '0;
            en_r_q    <= 1'b0;
            en_y_q    <= 1'b0;
            en_b_q    <= 1'b0;
            dir_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            color_q   <= color_d;
            sec_q     <= sec_d;
            rnd_q     <= rnd_d;
            rnds_r_q  <= rnds_r_d;
            rnds_y_q  <= rnds_y_d;
            rnds_b_q  <= rnds_b_d;
            // Outputs trail the state by one cycle, except that an abort
            // drops the motors on the same edge that returns to IDLE.
            en_r_q    <= !kill && (state_q == ST_R_DROP);
            en_y_q    <= !kill && (state_q == ST_Y_DROP);
            en_b_q    <= !kill && (state_q == ST_B_DROP);
            dir_q     <= !kill && is_drop && (sec_q >= SEC_W'(DEPTH));
            done_q    <= (state_q == ST_DONE);
            err_q     <= (state_q == ST_IDLE) && req_valid && !color_ok(req_color);
            aborted_q <= kill;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign phase     = state_q;
    assign en_r      = en_r_q;
    assign en_y      = en_y_q;
    assign en_b      = en_b_q;
    assign dir       = dir_q;
    assign done      = done_q;
    assign err       = err_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_dispense_scheduler.sv
module tb_dispense_scheduler;
    import dispense_pkg::*;

    localparam int STEP_DIV = 4;
    localparam int DEPTH    = 5;
    localparam int MOVE     = 2;
    localparam int RND_W    = 10;
    localparam int KD = STEP_DIV * 2 * DEPTH;  // cycles per stroke round
    localparam int KM = STEP_DIV * MOVE;       // cycles per carousel move

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [3:0] req_color;
    logic       abort;
    logic       req_ready, en_r, en_y, en_b, dir, busy, done, err, aborted;
    logic [3:0] phase;

    always #5 clk = ~clk;

    dispense_scheduler #(
        .STEP_DIV (STEP_DIV),
        .DEPTH    (DEPTH),
        .MOVE     (MOVE),
        .RND_W    (RND_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_color (req_color),
        .req_ready (req_ready),
        .abort     (abort),
        .en_r      (en_r),
        .en_y      (en_y),
        .en_b      (en_b),
        .dir       (dir),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .aborted   (aborted),
        .phase     (phase)
    );

    int passed = 0;
    int total  = 0;

    // ---------------- behavioural model ----------------
    int tbl [4][3] = '{'{5, 7, 9}, '{3, 0, 6}, '{0, 8, 2}, '{4, 4, 4}};
    int cyc     = 0;   // index of the most recent posedge
    bit m_run   = 1'b0;
    int m_e     = 0;   // posedge at which the current recipe was accepted
    int m_r = 0, m_y = 0, m_b = 0;
    int m_err_k = -1;
    int m_abt_k = -1;

    function automatic int rsum(input int r, input int y, input int b);
        return (r + y + b) * KD + 3 * KM;
    endfunction

    // State of a recipe o cycles after its accept edge; j = offset inside the phase.
    function automatic int state_at(input int o, input int r, input int y, input int b,
                                    output int j);
        int len  [6];
        int code [6];
        int u;
        len  = '{r * KD, KM, y * KD, KM, b * KD, KM};
        code = '{int'(ST_R_DROP), int'(ST_R2Y), int'(ST_Y_DROP),
                 int'(ST_Y2B), int'(ST_B_DROP), int'(ST_B2R)};
        j = 0;
        if (o < 0) return int'(ST_IDLE);
        if (o == 0) return int'(ST_LOAD);
        u = o - 1;
        for (int p = 0; p < 6; p++) begin
            if (u < len[p]) begin
                j = u;
                return code[p];
            end
            u = u - len[p];
        end
        return (u == 0) ? int'(ST_DONE) : int'(ST_IDLE);
    endfunction

    always @(posedge clk) begin : model_upd
        int op;
        int c;
        bit idle_before;
        cyc = cyc + 1;
        op = cyc - 1 - m_e;
        idle_before = !m_run || (op > rsum(m_r, m_y, m_b) + 1);
        if (!rst) begin
            m_run = 1'b0;
        end else if (m_run && op >= 0 && op <= rsum(m_r, m_y, m_b) && abort) begin
            m_run   = 1'b0;
            m_abt_k = cyc;
        end else if (idle_before && req_valid) begin
            if (req_color < 4'd4) begin
                c     = int'(req_color);
                m_run = 1'b1;
                m_e   = cyc;
                m_r   = tbl[c][0];
                m_y   = tbl[c][1];
                m_b   = tbl[c][2];
            end else begin
                m_err_k = cyc;
            end
        end
    end

    // ---------------- DUT-side measurements ----------------
    int cnt_enr = 0, cnt_eny = 0, cnt_enb = 0, cnt_dir = 0;
    int n_done = 0, n_err = 0, n_acc = 0, n_abt = 0;
    int acc_k = 0, done_k = 0, abt_k = 0, enr_rise_k = 0;
    bit prev_busy = 1'b0, prev_enr = 1'b0;

    // Advance one cycle and compare every output against the model.
    task automatic next_cycle();
        int st, pst, j, pj, o;
        bit e_drop;
        logic [12:0] exp_v;
        logic [12:0] act_v;
        @(negedge clk);
        st = int'(ST_IDLE); pst = st; j = 0; pj = 0;
        if (m_run) begin
            o   = cyc - m_e;
            st  = state_at(o, m_r, m_y, m_b, j);
            pst = state_at(o - 1, m_r, m_y, m_b, pj);
        end
        e_drop = (pst == int'(ST_R_DROP)) || (pst == int'(ST_Y_DROP)) || (pst == int'(ST_B_DROP));
        exp_v = {st == int'(ST_IDLE), st != int'(ST_IDLE),
                 pst == int'(ST_R_DROP), pst == int'(ST_Y_DROP), pst == int'(ST_B_DROP),
                 e_drop && (((pj / STEP_DIV) % (2 * DEPTH)) >= DEPTH),
                 pst == int'(ST_DONE), m_err_k == cyc, m_abt_k == cyc, 4'(st)};
        act_v = {req_ready, busy, en_r, en_y, en_b, dir, done, err, aborted, phase};
        total++;
        if (act_v === exp_v) passed++;
        else $display("FAIL outputs @cyc %0d: got rdy,busy,r,y,b,dir,done,err,abt,phase=%b required %b",
                      cyc, act_v, exp_v);
        cnt_enr += int'(en_r);
        cnt_eny += int'(en_y);
        cnt_enb += int'(en_b);
        cnt_dir += int'(dir);
        if (busy && !prev_busy) begin acc_k = cyc; n_acc++; end
        if (en_r && !prev_enr) enr_rise_k = cyc;
        if (done) begin done_k = cyc; n_done++; end
        if (err) n_err++;
        if (aborted) begin abt_k = cyc; n_abt++; end
        prev_busy = busy;
        prev_enr  = en_r;
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        bit seen;
        d0 = n_done;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            next_cycle();
            if (n_done != d0) seen = 1'b1;
        end
        total++;
        if (seen) passed++;
        else $display("FAIL %s: got no done within %0d cycles, required a done pulse", name, budget);
    endtask

    initial begin : stim
        int n0, sr, sy, sb, sd, se, sdn, sa;
        rst = 1'b0; req_valid = 1'b0; req_color = 4'd0; abort = 1'b0;

        // 1. reset then idle hold
        repeat (3) next_cycle();
        rst = 1'b1;
        repeat (20) next_cycle();
        check_int("idle_ready", int'(req_ready), 1);
        check_int("idle_enables", cnt_enr + cnt_eny + cnt_enb, 0);

        // 2. colour 0 full recipe
        sr = cnt_enr; sy = cnt_eny; sb = cnt_enb; sd = cnt_dir;
        req_valid = 1'b1; req_color = 4'd0;
        next_cycle();
        req_valid = 1'b0;
        n0 = acc_k;
        check_int("c0_accept_edge", n0, cyc);
        wait_done("c0_done", 1000);
        check_int("c0_done_at", done_k - n0, 866);
        check_int("c0_en_r_start", enr_rise_k - n0, 2);
        check_int("c0_en_r_len", cnt_enr - sr, 200);
        check_int("c0_en_y_len", cnt_eny - sy, 280);
        check_int("c0_en_b_len", cnt_enb - sb, 360);
        check_int("c0_dir_high", cnt_dir - sd, 420);
        next_cycle();
        check_int("c0_ready_again", int'(req_ready), 1);

        // 3. colour 1, yellow skipped
        sr = cnt_enr; sy = cnt_eny; sb = cnt_enb;
        req_valid = 1'b1; req_color = 4'd1;
        next_cycle();
        req_valid = 1'b0;
        n0 = acc_k;
        wait_done("c1_done", 600);
        check_int("c1_done_at", done_k - n0, 386);
        check_int("c1_en_r_len", cnt_enr - sr, 120);
        check_int("c1_en_y_len", cnt_eny - sy, 0);
        check_int("c1_en_b_len", cnt_enb - sb, 240);

        // 4. invalid colour
        se = n_err; sdn = n_done; sa = n_acc; sr = cnt_enr + cnt_eny + cnt_enb;
        req_valid = 1'b1; req_color = 4'd9;
        next_cycle();
        check_int("bad_err_pulse", int'(err), 1);
        req_valid = 1'b0;
        repeat (10) next_cycle();
        check_int("bad_err_count", n_err - se, 1);
        check_int("bad_no_accept", n_acc - sa, 0);
        check_int("bad_no_done", n_done - sdn, 0);
        check_int("bad_no_enable", cnt_enr + cnt_eny + cnt_enb - sr, 0);

        // 5. abort colour 3, then colour 2 runs normally
        sdn = n_done;
        req_valid = 1'b1; req_color = 4'd3;
        next_cycle();
        req_valid = 1'b0;
        n0 = acc_k;
        repeat (100) next_cycle();
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        check_int("abort_at", abt_k - n0, 101);
        check_int("abort_en_r_low", int'(en_r), 0);
        check_int("abort_busy_low", int'(busy), 0);
        req_valid = 1'b1; req_color = 4'd2;
        next_cycle();
        req_valid = 1'b0;
        check_int("abort_reaccept", acc_k - n0, 102);
        n0 = acc_k;
        wait_done("c2_done", 700);
        check_int("c2_done_at", done_k - n0, 426);
        check_int("abort_no_done", n_done - sdn, 1);

        // 6. back-pressure: request held through a whole recipe
        sa = n_acc;
        req_valid = 1'b1; req_color = 4'd0;
        next_cycle();
        n0 = acc_k;
        wait_done("bp_done", 1000);
        check_int("bp_single_accept", n_acc - sa, 1);
        next_cycle();
        check_int("bp_reaccept", acc_k - n0, 867);
        req_valid = 1'b0;
        repeat (5) next_cycle();
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        check_int("bp_abort", int'(aborted), 1);

        // 7. reset in the middle of a recipe
        req_valid = 1'b1; req_color = 4'd3;
        next_cycle();
        req_valid = 1'b0;
        repeat (50) next_cycle();
        rst = 1'b0;
        next_cycle();
        check_int("midrst_busy", int'(busy), 0);
        check_int("midrst_en_r", int'(en_r), 0);
        rst = 1'b1;
        next_cycle();

        // 8. abort while in DONE is ignored
        req_valid = 1'b1; req_color = 4'd2;
        next_cycle();
        req_valid = 1'b0;
        repeat (425) next_cycle();
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        check_int("done_abort_done", int'(done), 1);
        check_int("done_abort_ignored", int'(aborted), 0);

        // 9. randomized traffic, aborts and occasional resets
        for (int i = 0; i < 12000; i++) begin
            req_valid = ($urandom_range(0, 7) == 0);
            req_color = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15))
                                                    : 4'($urandom_range(0, 3));
            abort     = ($urandom_range(0, 399) == 0);
            rst       = ($urandom_range(0, 2999) != 0);
            next_cycle();
        end
        rst = 1'b1; abort = 1'b0; req_valid = 1'b0;
        repeat (2) next_cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dispense_scheduler.md
Name: dispense_scheduler

Overview:
Sequences the three colour dispense motors (red, yellow, blue) for one paint recipe per request. It accepts a colour_id over a valid/ready handshake and looks up per-channel stroke counts. It then walks the carousel: drop red, move, drop yellow, move, drop blue, move home. Its per-channel enable and shared direction outputs drive the existing stepper_motor_driver instances. It replaces the free-running colour sequencing in stepper_motor, and sits between the UI/recipe logic and the motor drivers.

Parameters:
STEP_DIV, 4, clk cycles per motor step tick (synthesis value 2**19; benches use 4)
DEPTH, 5, step ticks per stroke half (down or up); one stroke = 2*DEPTH ticks
MOVE, 2, step ticks spent in each carousel move phase
RND_W, 10, width of stroke-round counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (rst==0 resets on posedge clk)
req_valid  in  1  recipe request valid
req_color  in  4  colour_id of request
req_ready  out  1  high when the scheduler can accept a request (state IDLE)
abort  in  1  cancel current recipe
en_r  out  1  red motor enable
en_y  out  1  yellow motor enable
en_b  out  1  blue motor enable
dir  out  1  stroke direction, 0 = down, 1 = up
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a recipe completes
err  out  1  one-cycle pulse when a request carries an unsupported colour_id
aborted  out  1  one-cycle pulse when abort takes effect
phase  out  4  current state encoding, for debug/LEDs

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; all counters 0; en_*, dir, busy, done, err, aborted = 0; req_ready = 1 (it is a decode of state==IDLE). phase = IDLE.
- Recipe table, rounds R/Y/B:
  - colour 0: 5/7/9
  - colour 1: 3/0/6
  - colour 2: 0/8/2
  - colour 3: 4/4/4
  - colours 4-15: invalid
- States: IDLE, LOAD, R_DROP, R2Y, Y_DROP, Y2B, B_DROP, B2R, DONE.
- IDLE: on req_valid && req_ready:
  - valid colour: go to LOAD.
  - invalid colour: err=1 for the next cycle; stay IDLE.
- LOAD (1 cycle): latch the three round counts; clear tick counter, sec counter and round counter; go to R_DROP.
- Tick generator:
  - Counts 0..STEP_DIV-1 while in a drop or move state; held at 0 elsewhere.
  - tick=1 when count==STEP_DIV-1.
  - The counter is not reset between phases, so every phase lasts an exact multiple of STEP_DIV cycles.
- Drop states X_DROP:
  - en_X=1 for the whole state.
  - dir = (sec >= DEPTH).
  - On tick, sec increments and wraps at 2*DEPTH-1 to 0; on the wrap, rnd increments.
  - Exit on the tick where sec==2*DEPTH-1 and rnd==rounds_X-1; clear sec and rnd.
- Zero-round channel: its drop state is skipped. The preceding move goes directly to the following move, or R_DROP is skipped from LOAD. Skipping costs 0 cycles.
- Move states (R2Y, Y2B, B2R):
  - All enables 0; dir=0.
  - On tick, sec increments; exit on the tick where sec==MOVE-1; clear sec.
- DONE (1 cycle): done=1; next state IDLE.
- Duration: from the accept edge, busy covers 2 + STEP_DIV*((R+Y+B)*2*DEPTH + 3*MOVE) cycles before DONE.
- abort=1 in any state other than IDLE or DONE:
  - Next cycle: state=IDLE, all enables 0, aborted=1 for one cycle, done not asserted.
  - abort in IDLE is ignored.
  - abort in DONE is ignored; done still pulses.
- Requests while busy: req_ready=0; req_valid is ignored and nothing is queued.
- Outputs en_*, dir, done, err, aborted are registered, so they change one cycle after the state change that causes them.
- Reset asserted mid-recipe: all outputs return to reset values on that edge.

Decomposition:
- Package dispense_pkg:
  - State encoding localparams (4-bit).
  - Recipe table as a constant function rounds(colour, channel), plus a colour-valid check.
  - Channel indices R=0, Y=1, B=2.
- Sub-module step_tick_gen (STEP_DIV): inputs clk, rst, run; output tick.
- The state machine and counters stay in dispense_scheduler. The three stepper_motor_driver instances are outside this block.

Test Plan:
1. Reset release, idle hold: hold rst=0 for 3 cycles, then release with req_valid=0 -> req_ready=1, busy=0, all en_*=0 for 20 cycles.
2. Colour 0 full recipe (STEP_DIV=4, DEPTH=5, MOVE=2): accept at cycle N ->
   - en_r high for 200 cycles from N+2, with dir toggling every 20 cycles starting at 0.
   - en_y high for 280 cycles; en_b high for 360 cycles.
   - done pulse at N+866; req_ready=1 again at N+867.
3. Colour 1, yellow skipped -> en_y never asserts; en_r 120 cycles, en_b 240 cycles; done at N+386.
4. Invalid colour 9 -> err pulse one cycle after accept; state stays IDLE; no enable asserts; done never asserts.
5. Abort at cycle N+100 of a colour 3 recipe -> en_r drops at N+101; aborted=1 at N+101 for one cycle; busy=0; a colour 2 request accepted at N+102 runs normally.
6. Back-pressure: req_valid held high with colour 0 during a recipe -> req_ready=0 throughout and no second accept. After done, the request is accepted on the first IDLE cycle.
